// File: rtl/beep_seq.sv
// beep_seq: prioritised tone-pattern sequencer for the game buzzer.
// Plays EAT / START / DIE note patterns as a gated envelope (beep_en)
// and a square-wave tone (beep_out); mute gates outputs only.
module beep_seq #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned EAT_TICKS    = 2500000,
   parameter int unsigned NOTE_TICKS   = 7500000,
   parameter int unsigned GAP_TICKS    = 2500000,
   parameter int unsigned TONE_HI_HALF = 12500,
   parameter int unsigned TONE_LO_HALF = 25000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic evt_eat,
   input  logic evt_start,
   input  logic evt_die,
   input  logic mute,
   output logic beep_en,
   output logic beep_out,
   output logic busy
);

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
   // Pattern encoding doubles as priority: a larger value wins.
   typedef enum logic [1:0] {
      PAT_NONE  = 2'd0,
      PAT_EAT   = 2'd1,
      PAT_START = 2'd2,
      PAT_DIE   = 2'd3
   } pat_t;

   localparam logic [CNT_W-1:0] EAT_LD  = CNT_W'(EAT_TICKS - 1);
   localparam logic [CNT_W-1:0] NOTE_LD = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS - 1);
   localparam logic [CNT_W-1:0] HI_LD   = CNT_W'(TONE_HI_HALF - 1);
   localparam logic [CNT_W-1:0] LO_LD   = CNT_W'(TONE_LO_HALF - 1);

   state_t           state, state_n;
   pat_t             pat, pat_n, evt_pat;
   logic [1:0]       note_idx, idx_n;
   logic [CNT_W-1:0] dur_cnt, dur_n;
   logic [CNT_W-1:0] tone_cnt, tcnt_n;
   logic             tone_q, tq_n;
   logic             accept;

   function automatic logic [CNT_W-1:0] note_len(input pat_t p);
      return (p == PAT_EAT) ? EAT_LD : NOTE_LD;
   endfunction

   // START plays low then high; EAT is high; DIE is all low.
   function automatic logic [CNT_W-1:0] tone_half(input pat_t p, input logic [1:0] idx);
      return ((p == PAT_EAT) || ((p == PAT_START) && (idx == 2'd1))) ? HI_LD : LO_LD;
   endfunction

   function automatic logic [1:0] last_idx(input pat_t p);
      case (p)
         PAT_START: return 2'd1;
         PAT_DIE:   return 2'd2;
         default:   return 2'd0;
      endcase
   endfunction

   // Event priority decode and pre-emption decision.
   always_comb begin
      evt_pat = PAT_NONE;
      if (evt_die)        evt_pat = PAT_DIE;
      else if (evt_start) evt_pat = PAT_START;
      else if (evt_eat)   evt_pat = PAT_EAT;
      accept = (evt_pat != PAT_NONE) && (evt_pat >= pat);
   end

   // Next-state, counter and tone-phase logic.
   always_comb begin
      state_n = state;
      pat_n   = pat;
      idx_n   = note_idx;
      dur_n   = dur_cnt;
      tcnt_n  = tone_cnt;
      tq_n    = tone_q;
      if (accept) begin
         state_n = NOTE;
         pat_n   = evt_pat;
         idx_n   = '0;
         dur_n   = note_len(evt_pat);
         tcnt_n  = tone_half(evt_pat, 2'd0);
         tq_n    = 1'b1;
      end else begin
         case (state)
            NOTE: begin
               if (dur_cnt == '0) begin
                  if (note_idx == last_idx(pat)) begin
                     state_n = IDLE;
                     pat_n   = PAT_NONE;
                     idx_n   = '0;
                  end else begin
                     state_n = GAP;
                     dur_n   = GAP_LD;
                  end
               end else begin
                  dur_n = dur_cnt - 1'b1;
                  if (tone_cnt == '0) begin
                     tq_n   = ~tone_q;
                     tcnt_n = tone_half(pat, note_idx);
                  end else begin
                     tcnt_n = tone_cnt - 1'b1;
                  end
               end
            end
            GAP: begin
               if (dur_cnt == '0) begin
                  state_n = NOTE;
                  idx_n   = note_idx + 2'd1;
                  dur_n   = note_len(pat);
                  tcnt_n  = tone_half(pat, note_idx + 2'd1);
                  tq_n    = 1'b1;
               end else begin
                  dur_n = dur_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         pat      <= PAT_NONE;
         note_idx <= '0;
         dur_cnt  <= '0;
         tone_cnt <= '0;
         tone_q   <= 1'b0;
         beep_en  <= 1'b0;
         beep_out <= 1'b0;
      end else begin
         state    <= state_n;
         pat      <= pat_n;
         note_idx <= idx_n;
         dur_cnt  <= dur_n;
         tone_cnt <= tcnt_n;
         tone_q   <= tq_n;
         beep_en  <= (state_n == NOTE) & ~mute;
         beep_out <= tq_n & (state_n == NOTE) & ~mute;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_beep_seq.sv
// Self-checking bench for beep_seq with small tick parameters.
// Cycle c is the interval after rising edge c; inputs driven in cycle c
// are captured at edge c+1.
module tb_beep_seq;

   localparam int EAT_T = 10;
   localparam int NOTE_T = 8;
   localparam int GAP_T = 4;
   localparam int HI_H = 2;
   localparam int LO_H = 3;
   localparam int N = 90;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic evt_eat = 1'b0, evt_start = 1'b0, evt_die = 1'b0, mute = 1'b0;
   logic beep_en, beep_out, busy;

   int checks = 0;
   int errors = 0;

   logic [2:0] ev [N];   // {die, start, eat} per cycle
   logic       mu [N];
   logic       obs_en [N], obs_out [N], obs_busy [N];
   logic       exp_en [N], exp_out [N], exp_busy [N];

   beep_seq #(
      .CNT_W(32), .EAT_TICKS(EAT_T), .NOTE_TICKS(NOTE_T), .GAP_TICKS(GAP_T),
      .TONE_HI_HALF(HI_H), .TONE_LO_HALF(LO_H)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .evt_eat(evt_eat),
      .evt_start(evt_start), .evt_die(evt_die), .mute(mute),
      .beep_en(beep_en), .beep_out(beep_out), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic clear_stim();
      for (int i = 0; i < N; i++) begin
         ev[i] = 3'b000;
         mu[i] = 1'b0;
      end
   endtask

   task automatic do_reset();
      {evt_die, evt_start, evt_eat} = 3'b000;
      mute = 1'b0;
      sys_rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge sys_clk);
         #1;
         {evt_die, evt_start, evt_eat} = ev[c];
         mute = mu[c];
         @(negedge sys_clk);
         obs_en[c] = beep_en;
         obs_out[c] = beep_out;
         obs_busy[c] = busy;
      end
      {evt_die, evt_start, evt_eat} = 3'b000;
      mute = 1'b0;
   endtask

   // Pattern-level reference: an accepted event starts a pattern whose
   // notes are laid out at fixed offsets; outputs follow by arithmetic.
   function automatic void build_model(input int n);
      int s, p;
      s = 0;
      p = 0;
      for (int c = 0; c < n; c++) begin
         int q, len, slot, total, o, k, r, half;
         logic m;
         q = 0;
         if (c > 0) begin
            if (ev[c-1][2]) q = 3;
            else if (ev[c-1][1]) q = 2;
            else if (ev[c-1][0]) q = 1;
            if (!exp_busy[c-1]) p = 0;
            if (q != 0 && q >= p) begin
               p = q;
               s = c - 1;
            end
         end
         m = (c > 0) ? mu[c-1] : 1'b0;
         exp_en[c] = 1'b0;
         exp_out[c] = 1'b0;
         exp_busy[c] = 1'b0;
         if (p != 0) begin
            len = (p == 1) ? EAT_T : NOTE_T;
            slot = len + GAP_T;
            total = p * len + (p - 1) * GAP_T;  // notes in pattern == priority
            o = c - s - 1;
            if (o < total) begin
               exp_busy[c] = 1'b1;
               k = o / slot;
               r = o % slot;
               if (r < len) begin
                  half = (p == 1 || (p == 2 && k == 1)) ? HI_H : LO_H;
                  exp_en[c] = !m;
                  exp_out[c] = !m && (((r / half) % 2) == 0);
               end
            end
         end
      end
   endfunction

   task automatic test_reset();
      #1;
      checks++;
      if ({beep_en, beep_out, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_state got=%b want=000", {beep_en, beep_out, busy});
      end
      do_reset();
      @(negedge sys_clk);
      checks++;
      if ({beep_en, beep_out, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release got=%b want=000", {beep_en, beep_out, busy});
      end
   endtask

   task automatic test_eat();
      logic e;
      do_reset();
      clear_stim();
      ev[5] = 3'b001;
      run(20);
      build_model(20);
      for (int c = 0; c < 20; c++) begin
         checks++;
         if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
            errors++;
            $display("FAIL eat cyc %0d en/out/busy got=%b want=%b", c,
                     {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
         end
      end
      for (int i = 0; i < 10; i++) begin
         e = ((i % 4) < 2);
         checks++;
         if ({obs_en[6+i], obs_out[6+i]} !== {1'b1, e}) begin
            errors++;
            $display("FAIL eat_tone cyc %0d got=%b want=%b", 6 + i, {obs_en[6+i], obs_out[6+i]}, {1'b1, e});
         end
      end
      checks++;
      if ({obs_en[16], obs_out[16], obs_busy[16], obs_busy[15]} !== 4'b0001) begin
         errors++;
         $display("FAIL eat_end got=%b want=0001", {obs_en[16], obs_out[16], obs_busy[16], obs_busy[15]});
      end
   endtask

   task automatic test_start();
      logic [7:0] n0, n1;
      do_reset();
      clear_stim();
      ev[0] = 3'b010;
      run(24);
      build_model(24);
      for (int c = 0; c < 24; c++) begin
         checks++;
         if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
            errors++;
            $display("FAIL start cyc %0d en/out/busy got=%b want=%b", c,
                     {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
         end
      end
      for (int i = 0; i < 8; i++) begin
         n0[7-i] = obs_out[1+i];
         n1[7-i] = obs_out[13+i];
      end
      checks++;
      if ({n0, n1} !== {8'b11100011, 8'b11001100}) begin
         errors++;
         $display("FAIL start_tone got=%b_%b want=11100011_11001100", n0, n1);
      end
      checks++;
      if ({obs_en[9], obs_en[12], obs_en[13], obs_busy[20], obs_busy[21]} !== 5'b00110) begin
         errors++;
         $display("FAIL start_edges got=%b want=00110",
                  {obs_en[9], obs_en[12], obs_en[13], obs_busy[20], obs_busy[21]});
      end
   endtask

   task automatic test_die_eat();
      do_reset();
      clear_stim();
      ev[0] = 3'b101;
      run(36);
      build_model(36);
      for (int c = 0; c < 36; c++) begin
         checks++;
         if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
            errors++;
            $display("FAIL die_eat cyc %0d en/out/busy got=%b want=%b", c,
                     {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
         end
      end
      checks++;
      if ({obs_en[25], obs_en[32], obs_busy[32], obs_busy[33]} !== 4'b1110) begin
         errors++;
         $display("FAIL die_edges got=%b want=1110", {obs_en[25], obs_en[32], obs_busy[32], obs_busy[33]});
      end
   endtask

   task automatic test_preempt();
      do_reset();
      clear_stim();
      ev[0] = 3'b001;
      ev[4] = 3'b010;
      ev[7] = 3'b001;
      run(26);
      build_model(26);
      for (int c = 0; c < 26; c++) begin
         checks++;
         if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
            errors++;
            $display("FAIL preempt cyc %0d en/out/busy got=%b want=%b", c,
                     {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
         end
      end
      checks++;
      if ({obs_en[13], obs_en[17], obs_en[24], obs_busy[25]} !== 4'b0110) begin
         errors++;
         $display("FAIL preempt_edges got=%b want=0110", {obs_en[13], obs_en[17], obs_en[24], obs_busy[25]});
      end
   endtask

   task automatic test_mute();
      do_reset();
      clear_stim();
      ev[0] = 3'b001;
      for (int i = 2; i <= 4; i++) mu[i] = 1'b1;
      run(14);
      build_model(14);
      for (int c = 0; c < 14; c++) begin
         checks++;
         if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
            errors++;
            $display("FAIL mute cyc %0d en/out/busy got=%b want=%b", c,
                     {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
         end
      end
      checks++;
      if ({obs_en[3], obs_en[5], obs_busy[4], obs_en[6], obs_out[6]} !== 5'b00111) begin
         errors++;
         $display("FAIL mute_resume got=%b want=00111",
                  {obs_en[3], obs_en[5], obs_busy[4], obs_en[6], obs_out[6]});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      clear_stim();
      ev[0] = 3'b100;
      run(16);
      checks++;
      if ({obs_en[15], obs_busy[15]} !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset_active got=%b want=11", {obs_en[15], obs_busy[15]});
      end
      #1 sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({beep_en, beep_out, busy} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset got=%b want=000", {beep_en, beep_out, busy});
      end
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      clear_stim();
      ev[6] = 3'b001;
      run(20);
      build_model(20);
      for (int c = 0; c < 20; c++) begin
         checks++;
         if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
            errors++;
            $display("FAIL after_reset cyc %0d en/out/busy got=%b want=%b", c,
                     {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         do_reset();
         clear_stim();
         for (int c = 0; c < N - 1; c++) begin
            if ($urandom_range(0, 14) == 0) ev[c] = 3'($urandom_range(1, 7));
            mu[c] = ($urandom_range(0, 7) == 0);
         end
         run(N);
         build_model(N);
         for (int c = 0; c < N; c++) begin
            checks++;
            if ({obs_en[c], obs_out[c], obs_busy[c]} !== {exp_en[c], exp_out[c], exp_busy[c]}) begin
               errors++;
               $display("FAIL random it %0d cyc %0d en/out/busy got=%b want=%b", it, c,
                        {obs_en[c], obs_out[c], obs_busy[c]}, {exp_en[c], exp_out[c], exp_busy[c]});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_eat();
      test_start();
      test_die_eat();
      test_preempt();
      test_mute();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
